axi_wr_responder: RTL and testbench

- Slave-side AXI write responder on the clk2 domain; it is the consumer end of the write-channel CDC.
- Pops AW commands and W beats from the write-channel async FIFOs and turns them into word writes on a local SRAM-style port.
- Pushes one B response per burst into the B FIFO, which returns it to the master domain.
- Runs on one clock, with synchronous active-high reset.

---
 rtl/axi_wr_responder.sv | 214 +++++++++++++++++++++
 tb/tb_axi_wr_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_wr_responder
// Description : Slave-side AXI write responder (consumer end of the write
//               channel CDC). Pops AW commands and W beats from first-word
//               fall-through FIFOs, turns them into word writes on an
//               SRAM-style port and pushes one B response per burst.
// Ports       : clk, rst           - clock / synchronous active-high reset
//               AW_not_empty/AW_r_data/AW_rd_en - AW FIFO read side
//               W_not_empty/W_r_data/W_rd_en    - W FIFO read side
//               B_not_full/B_w_data/B_wr_en     - B FIFO write side
//               mem_we/mem_addr/mem_wdata/mem_bwe/mem_ready - memory port
// Options     : AXI_WR_LAST_CHK_EN - check W last on every beat, terminate
//               early bursts and drain over-long bursts with SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] SIZE_BYTES = 32'h0001_0000,
  parameter int          MEM_AW     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AW_not_empty,
  input  logic [48:0]       AW_r_data,
  output logic              AW_rd_en,
  input  logic              W_not_empty,
  input  logic [36:0]       W_r_data,
  output logic              W_rd_en,
  input  logic              B_not_full,
  output logic [9:0]        B_w_data,
  output logic              B_wr_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bwe,
  input  logic              mem_ready
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_BRESP = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_id;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_cnt;
  logic [1:0]  r_resp;

  // AW head fields
  logic [7:0]  w_aw_id;
  logic [31:0] w_aw_addr;
  logic [3:0]  w_aw_len;
  logic [2:0]  w_aw_size;
  logic [1:0]  w_aw_burst;
  logic [31:0] w_aw_rel;
  logic [1:0]  w_aw_resp;

  assign w_aw_id    = AW_r_data[48:41];
  assign w_aw_addr  = AW_r_data[40:9];
  assign w_aw_len   = AW_r_data[8:5];
  assign w_aw_size  = AW_r_data[4:2];
  assign w_aw_burst = AW_r_data[1:0];

  // Window test by unsigned offset: also rejects addresses below BASE_ADDR,
  // which wrap to a huge offset.
  assign w_aw_rel  = w_aw_addr - BASE_ADDR;
  assign w_aw_resp = (w_aw_rel >= SIZE_BYTES) ? c_RESP_DECERR :
                     (w_aw_size > 3'd2)      ? c_RESP_SLVERR : c_RESP_OKAY;

  // W head fields
  logic [31:0] w_w_data;
  logic [3:0]  w_w_strb;
  assign w_w_data = W_r_data[36:5];
  assign w_w_strb = W_r_data[4:1];

  // Next beat address
  logic [31:0] w_incr;
  logic [31:0] w_wrap_mask;
  logic [31:0] w_addr_inc;
  logic [31:0] w_next_addr;
  logic [31:0] w_rel;

  assign w_incr      = 32'd1 << r_size;
  assign w_wrap_mask = (({28'd0, r_len} + 32'd1) << r_size) - 32'd1;
  assign w_addr_inc  = r_addr + w_incr;
  assign w_rel       = r_addr - BASE_ADDR;

  always_comb begin
    w_next_addr = w_addr_inc;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      // WRAP keeps the upper bits and lets only the low bits roll over
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_next_addr = w_addr_inc;
    endcase
  end

  // Handshakes are decoded from the registered state so that a beat can be
  // written and popped in the same cycle mem_ready is seen.
  logic w_ok;
  logic w_beat_last;
  logic w_aw_pop;
  logic w_w_pop;
  logic w_mem_we;
  logic w_b_push;
  logic w_drive;

  assign w_ok        = (r_resp == c_RESP_OKAY);
  assign w_beat_last = (r_cnt == r_len);
  assign w_aw_pop    = !rst && (r_state == S_IDLE) && AW_not_empty;
  assign w_mem_we    = !rst && (r_state == S_WDATA) && W_not_empty && w_ok;
  assign w_b_push    = !rst && (r_state == S_BRESP) && B_not_full;
  assign w_drive     = !rst && (r_state == S_WDATA);

`ifdef AXI_WR_LAST_CHK_EN
  logic       w_w_last;
  logic [1:0] w_resp_err;
  assign w_w_last   = W_r_data[0];
  // A framing error never downgrades an address decode error
  assign w_resp_err = (r_resp == c_RESP_DECERR) ? c_RESP_DECERR : c_RESP_SLVERR;
  assign w_w_pop    = !rst && W_not_empty &&
                      (((r_state == S_WDATA) && (!w_ok || mem_ready)) ||
                       (r_state == S_DRAIN));
`else
  logic w_unused_last;
  assign w_unused_last = W_r_data[0];
  assign w_w_pop       = !rst && W_not_empty && (r_state == S_WDATA) &&
                         (!w_ok || mem_ready);
`endif

  assign AW_rd_en  = w_aw_pop;
  assign W_rd_en   = w_w_pop;
  assign B_wr_en   = w_b_push;
  assign B_w_data  = (!rst && (r_state == S_BRESP)) ? {r_id, r_resp} : 10'd0;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_drive ? w_rel[MEM_AW+1:2] : '0;
  assign mem_wdata = w_drive ? w_w_data : 32'd0;
  assign mem_bwe   = w_drive ? w_w_strb : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_pop) begin
            r_id    <= w_aw_id;
            r_addr  <= w_aw_addr;
            r_len   <= w_aw_len;
            r_size  <= w_aw_size;
            r_burst <= w_aw_burst;
            r_cnt   <= 4'd0;
            r_resp  <= w_aw_resp;
            r_state <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_w_pop) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 4'd1;
`ifdef AXI_WR_LAST_CHK_EN
            // last and the beat count disagree: early last ends the burst,
            // missing last sends the rest of the burst to DRAIN
            if (w_w_last != w_beat_last) begin
              r_resp  <= w_resp_err;
              r_state <= w_w_last ? S_BRESP : S_DRAIN;
            end else if (w_beat_last) begin
              r_state <= S_BRESP;
            end
`else
            if (w_beat_last) begin
              r_state <= S_BRESP;
            end
`endif
          end
        end
`ifdef AXI_WR_LAST_CHK_EN
        S_DRAIN: begin
          if (w_w_pop && w_w_last) begin
            r_state <= S_BRESP;
          end
        end
`endif
        S_BRESP: begin
          if (w_b_push) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_wr_responder
// Description : Self-checking bench for axi_wr_responder. Emulates the AW, W
//               and B FIFOs and the memory, and compares every cycle against
//               a burst-level reference model (per-beat write plan + B value).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  localparam int          MAW  = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           AW_not_empty, W_not_empty, B_not_full, mem_ready;
  logic [48:0]    AW_r_data;
  logic [36:0]    W_r_data;
  logic           AW_rd_en, W_rd_en, B_wr_en, mem_we;
  logic [9:0]     B_w_data;
  logic [MAW-1:0] mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_bwe;

  axi_wr_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .MEM_AW(MAW)) dut (
    .clk(clk), .rst(rst),
    .AW_not_empty(AW_not_empty), .AW_r_data(AW_r_data), .AW_rd_en(AW_rd_en),
    .W_not_empty(W_not_empty), .W_r_data(W_r_data), .W_rd_en(W_rd_en),
    .B_not_full(B_not_full), .B_w_data(B_w_data), .B_wr_en(B_wr_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bwe(mem_bwe), .mem_ready(mem_ready)
  );

  typedef struct {
    bit           wr;
    bit [MAW-1:0] maddr;
    bit [31:0]    data;
    bit [3:0]     bwe;
  } beat_t;

  typedef struct {
    int      nb;
    bit [9:0] b;
  } burst_t;

  bit [48:0] awq[$];
  bit [36:0] wq[$];
  beat_t     plan_q[$];
  burst_t    bq[$];
  bit        rdy_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 = waiting for AW, 1 = taking beats, 2 = owing a B
  int       phase = 0;
  int       left  = 0;
  bit [9:0] cur_b;

  bit pop_aw, pop_w, push_b;
  int nbpush = 0, nwr = 0, nwpop = 0;
  bit [MAW-1:0] last_waddr;
  bit [31:0]    last_wdata;
  bit [9:0]     last_b;
  bit rand_en = 0, bnf_block = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit [31:0] beat_addr(input bit [31:0] a0, input int len,
                                          input int size, input bit [1:0] burst, input int i);
    longint unsigned inc, w, lower, a;
    inc = 64'd1 << size;
    a   = a0;
    case (burst)
      2'b00: return a0;
      2'b10: begin
        w     = longint'(len + 1) * inc;
        lower = a - (a % w);
        return 32'(lower + ((a - lower + longint'(i) * inc) % w));
      end
      default: return 32'(a + longint'(i) * inc);
    endcase
  endfunction

  function automatic bit [1:0] aw_resp(input bit [31:0] a, input int size);
    longint unsigned la, lb, ls;
    la = a; lb = BASE; ls = SIZE;
    if (la < lb || la >= lb + ls) return 2'b11;
    if (size > 2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit [MAW-1:0] maddr_of(input bit [31:0] a);
    bit [31:0] r;
    r = (a - BASE) >> 2;
    return r[MAW-1:0];
  endfunction

  task automatic gen_burst(input bit [7:0] id, input bit [31:0] a0, input int len,
                           input int size, input bit [1:0] burst, input int lastpos,
                           input bit fix0, input bit [31:0] d0, input bit [3:0] s0);
    int nb; bit [1:0] r0, rf; bit lst; beat_t bt; burst_t bb;
    r0 = aw_resp(a0, size);
`ifdef AXI_WR_LAST_CHK_EN
    nb = lastpos + 1;
    rf = (r0 != 2'b11 && lastpos != len) ? 2'b10 : r0;
`else
    nb = len + 1;
    rf = r0;
`endif
    awq.push_back({id, a0, 4'(len), 3'(size), burst});
    for (int i = 0; i < nb; i++) begin
      bt.data = (fix0 && i == 0) ? d0 : $urandom;
      bt.bwe  = (fix0 && i == 0) ? s0 : 4'($urandom);
`ifdef AXI_WR_LAST_CHK_EN
      lst = (i == lastpos);
`else
      lst = ($urandom % 2) == 1;
`endif
      bt.wr    = (r0 == 2'b00) && (i <= len);
      bt.maddr = maddr_of(beat_addr(a0, len, size, burst, i));
      wq.push_back({bt.data, bt.bwe, lst});
      plan_q.push_back(bt);
    end
    bb.nb = nb;
    bb.b  = {id, rf};
    bq.push_back(bb);
  endtask

  task automatic gen_random();
    bit [1:0] bu; int len, size, sel, lp; bit [31:0] a;
    bu   = 2'($urandom);
    len  = (bu == 2'b10) ? ((1 << (1 + $urandom % 4)) - 1) : int'($urandom % 16);
    size = ($urandom % 8 == 0) ? int'(3 + $urandom % 5) : int'($urandom % 3);
    sel  = $urandom % 8;
    if (sel == 0)      a = BASE + SIZE + ($urandom % 4096);
    else if (sel == 1) a = BASE - 1 - ($urandom % 4096);
    else               a = BASE + ($urandom % SIZE);
    lp = ($urandom % 4 == 0) ? int'($urandom % (len + 3)) : len;
    gen_burst(8'($urandom), a, len, size, bu, lp, 1'b0, 32'd0, 4'd0);
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    bit exp_aw, exp_we, exp_wrd, exp_b;
    beat_t hd; burst_t cb;
    forever begin
      @(negedge clk);
      if (rst) begin
        pop_aw = 0; pop_w = 0; push_b = 0;
      end else begin
        exp_aw  = (phase == 0) && AW_not_empty;
        exp_we  = 0;
        exp_wrd = 0;
        if (phase == 1) begin
          if (plan_q.size() == 0) chk("plan_underflow", 1, 0);
          else begin
            hd      = plan_q[0];
            exp_we  = W_not_empty && hd.wr;
            exp_wrd = W_not_empty && (hd.wr ? mem_ready : 1'b1);
          end
        end
        exp_b = (phase == 2) && B_not_full;
        chk("AW_rd_en", AW_rd_en, exp_aw);
        chk("W_rd_en", W_rd_en, exp_wrd);
        chk("mem_we", mem_we, exp_we);
        chk("B_wr_en", B_wr_en, exp_b);
        if (exp_we) begin
          chk("mem_addr", mem_addr, hd.maddr);
          chk("mem_wdata", mem_wdata, hd.data);
          chk("mem_bwe", mem_bwe, hd.bwe);
        end
        if (exp_b) chk("B_w_data", B_w_data, cur_b);
        if (mem_we && mem_ready) begin
          nwr++; last_waddr = mem_addr; last_wdata = mem_wdata;
        end
        if (W_rd_en) nwpop++;
        if (B_wr_en) last_b = B_w_data;
        pop_aw = AW_rd_en; pop_w = W_rd_en; push_b = B_wr_en;
        case (phase)
          0: if (exp_aw && bq.size() > 0) begin
               cb = bq.pop_front(); left = cb.nb; cur_b = cb.b; phase = 1;
             end
          1: if (exp_wrd) begin
               void'(plan_q.pop_front()); left--;
               if (left == 0) phase = 2;
             end
          default: if (exp_b) phase = 0;
        endcase
      end
    end
  end

  // ---------------- driver ----------------
  task automatic refresh();
    bit av;
    av = rand_en ? ($urandom % 5 != 0) : 1'b1;
    AW_not_empty = (awq.size() > 0) && av;
    AW_r_data    = (awq.size() > 0) ? awq[0] : 49'd0;
    av = rand_en ? ($urandom % 5 != 0) : 1'b1;
    W_not_empty  = (wq.size() > 0) && av;
    W_r_data     = (wq.size() > 0) ? wq[0] : 37'd0;
    if (rdy_q.size() > 0) mem_ready = rdy_q.pop_front();
    else                  mem_ready = rand_en ? ($urandom % 4 != 0) : 1'b1;
    B_not_full = bnf_block ? 1'b0 : (rand_en ? ($urandom % 3 != 0) : 1'b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (pop_aw && awq.size() > 0) void'(awq.pop_front());
    if (pop_w && wq.size() > 0)   void'(wq.pop_front());
    if (push_b) nbpush++;
    pop_aw = 0; pop_w = 0; push_b = 0;
    refresh();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((awq.size() > 0 || bq.size() > 0 || phase != 0) && k < budget) begin
      cycle();
      k++;
    end
    chk({name, "_timeout"}, k < budget, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_AW_rd_en"}, AW_rd_en, 0);
    chk({tag, "_W_rd_en"}, W_rd_en, 0);
    chk({tag, "_B_wr_en"}, B_wr_en, 0);
    chk({tag, "_B_w_data"}, B_w_data, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_bwe"}, mem_bwe, 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    int n0, nw0, np0, k;
    // reset with busy-looking inputs: everything must stay quiet
    rst = 1;
    AW_not_empty = 1; AW_r_data = {17'h1abcd, 32'h1234_5678};
    W_not_empty  = 1; W_r_data  = {5'h1f, 32'hcafe_f00d};
    B_not_full   = 1; mem_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    // pin the model with hand-computed values
    chk("pin_wrap0", maddr_of(beat_addr(BASE + 32'h8, 3, 2, 2'b10, 0)), 2);
    chk("pin_wrap1", maddr_of(beat_addr(BASE + 32'h8, 3, 2, 2'b10, 1)), 3);
    chk("pin_wrap2", maddr_of(beat_addr(BASE + 32'h8, 3, 2, 2'b10, 2)), 0);
    chk("pin_wrap3", maddr_of(beat_addr(BASE + 32'h8, 3, 2, 2'b10, 3)), 1);
    chk("pin_incr", maddr_of(beat_addr(BASE + 32'h10, 0, 2, 2'b01, 0)), 4);
    chk("pin_decerr", aw_resp(BASE + SIZE, 2), 2'b11);
    chk("pin_slverr", aw_resp(BASE, 3), 2'b10);
    chk("pin_okay", aw_resp(BASE + SIZE - 4, 2), 2'b00);

    @(posedge clk); #1;
    rst = 0;
    refresh();
    cycle();

    // single write
    n0 = nbpush; nw0 = nwr;
    gen_burst(8'h3, BASE + 32'h10, 0, 2, 2'b01, 0, 1'b1, 32'hDEADBEEF, 4'hF);
    wait_idle(100, "single");
    chk("single_nwr", nwr - nw0, 1);
    chk("single_addr", last_waddr, 4);
    chk("single_data", last_wdata, 32'hDEADBEEF);
    chk("single_b", last_b, {8'h3, 2'b00});
    chk("single_bpush", nbpush - n0, 1);

    // INCR burst with ready toggling (first entry covers the AW cycle)
    n0 = nbpush; nw0 = nwr;
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    gen_burst(8'h1, BASE, 3, 2, 2'b01, 3, 1'b0, 32'd0, 4'd0);
    wait_idle(100, "incr");
    chk("incr_nwr", nwr - nw0, 4);
    chk("incr_last_addr", last_waddr, 3);
    chk("incr_bpush", nbpush - n0, 1);

    // WRAP burst
    nw0 = nwr;
    gen_burst(8'h2, BASE + 32'h8, 3, 2, 2'b10, 3, 1'b0, 32'd0, 4'd0);
    wait_idle(100, "wrap");
    chk("wrap_nwr", nwr - nw0, 4);
    chk("wrap_last_addr", last_waddr, 1);
    chk("wrap_b", last_b, {8'h2, 2'b00});

    // out of window
    nw0 = nwr; np0 = nwpop;
    gen_burst(8'h4, BASE + SIZE, 1, 2, 2'b01, 1, 1'b0, 32'd0, 4'd0);
    wait_idle(100, "decerr");
    chk("decerr_nwr", nwr - nw0, 0);
    chk("decerr_wpops", nwpop - np0, 2);
    chk("decerr_b", last_b, {8'h4, 2'b11});

    // B backpressure
    n0 = nbpush;
    bnf_block = 1;
    gen_burst(8'h5, BASE + 32'h40, 1, 2, 2'b01, 1, 1'b0, 32'd0, 4'd0);
    k = 0;
    while (phase != 2 && k < 100) begin cycle(); k++; end
    chk("bp_reach_resp", k < 100, 1);
    repeat (5) cycle();
    chk("bp_held", nbpush - n0, 0);
    bnf_block = 0;
    wait_idle(100, "bp");
    chk("bp_one_push", nbpush - n0, 1);
    chk("bp_b", last_b, {8'h5, 2'b00});

    // reset in the middle of a burst
    nw0 = nwr;
    gen_burst(8'h6, BASE + 32'h80, 7, 2, 2'b01, 7, 1'b0, 32'd0, 4'd0);
    k = 0;
    while (nwr - nw0 < 2 && k < 100) begin cycle(); k++; end
    chk("midrst_reach", k < 100, 1);
    rst = 1;
    awq.delete(); wq.delete(); plan_q.delete(); bq.delete(); rdy_q.delete();
    phase = 0; left = 0;
    refresh();
    n0 = nbpush;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1;
    rst = 0;
    refresh();
    repeat (5) cycle();
    chk("midrst_no_b", nbpush - n0, 0);

`ifdef AXI_WR_LAST_CHK_EN
    // early last
    nw0 = nwr; np0 = nwpop;
    gen_burst(8'h7, BASE + 32'h100, 3, 2, 2'b01, 1, 1'b0, 32'd0, 4'd0);
    wait_idle(100, "early");
    chk("early_nwr", nwr - nw0, 2);
    chk("early_wpops", nwpop - np0, 2);
    chk("early_b", last_b, {8'h7, 2'b10});
    // late last: drained
    nw0 = nwr; np0 = nwpop;
    gen_burst(8'h8, BASE + 32'h200, 1, 2, 2'b01, 3, 1'b0, 32'd0, 4'd0);
    wait_idle(100, "late");
    chk("late_nwr", nwr - nw0, 2);
    chk("late_wpops", nwpop - np0, 4);
    chk("late_b", last_b, {8'h8, 2'b10});
`endif

    // randomized traffic
    rand_en = 1;
    for (int b = 0; b < 200; b++) begin
      int nq;
      nq = 1 + int'($urandom % 3);
      for (int j = 0; j < nq; j++) gen_random();
      wait_idle(3000, "rand");
    end
    rand_en = 0;
    repeat (3) cycle();
    chk("leftover_plan", plan_q.size(), 0);
    chk("leftover_w", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
